// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialisation sequencer: explicit FSM with one shared gap counter and a DLL-lock counter.
// Optional OCD default/exit EMR1 writes are included when DDR2_OCD_EN is defined.
module ddr2_init_seq #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 13,
  parameter int T_PWR_CYC = 60000,
  parameter int T_CKE_CYC = 100,
  parameter int T_RP_CYC  = 4,
  parameter int T_MRD_CYC = 2,
  parameter int T_RFC_CYC = 26,
  parameter int N_AREF    = 2,
  parameter int T_DLL_CYC = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] mr_val,
  input  logic [ADDR_BITS-1:0] emr1_val,
  input  logic [ADDR_BITS-1:0] emr2_val,
  input  logic [ADDR_BITS-1:0] emr3_val,
  input  logic                 reinit_req,
  output logic                 init_cke,
  output logic [3:0]           init_cmd,
  output logic [BA_BITS-1:0]   init_ba,
  output logic [ADDR_BITS-1:0] init_addr,
  output logic                 ddr2_odt,
  output logic                 init_busy,
  output logic                 init_end
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LM   = 4'b0000;

  localparam int CW = $clog2(T_PWR_CYC + T_CKE_CYC + T_RP_CYC + T_MRD_CYC + T_RFC_CYC + 1);
  localparam int DW = $clog2(T_DLL_CYC + 2);
  localparam int AW = $clog2(N_AREF + 1);

  localparam logic [ADDR_BITS-1:0] ADDR_A10 = ADDR_BITS'(1024);

  typedef enum logic [3:0] {
    S_WAIT_PWR, S_WAIT_CKE, S_PRE1, S_EMR2, S_EMR3, S_EMR1_DLL, S_MR_DLLRST, S_PRE2,
    S_AREF, S_MR_FINAL, S_EMR1_OCD_DEF, S_EMR1_OCD_EXIT, S_EMR1_FINAL, S_WAIT_DLL, S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [DW-1:0]         dll_cnt, dll_nxt;
  logic [AW-1:0]         aref_cnt, aref_nxt;
  logic                  cke_nxt, end_nxt, busy_nxt, capture;
  logic [3:0]            cmd_nxt;
  logic [BA_BITS-1:0]    ba_nxt;
  logic [ADDR_BITS-1:0]  addr_nxt;
  logic [ADDR_BITS-1:0]  mr_q, emr1_q, emr2_q, emr3_q;

  // A command issued now is followed by the next one exactly t cycles later.
  function automatic logic [CW-1:0] gap(input int t);
    return CW'(t - 1);
  endfunction

  function automatic logic [ADDR_BITS-1:0] mr_word(input logic [ADDR_BITS-1:0] v, input logic dll_rst);
    logic [ADDR_BITS-1:0] r;
    r    = v;
    r[8] = dll_rst;
    return r;
  endfunction

  // DLL stays enabled (A0=0); A9:A7 selects OCD default (111) or exit (000).
  function automatic logic [ADDR_BITS-1:0] emr1_word(input logic [ADDR_BITS-1:0] v, input logic ocd_def);
    logic [ADDR_BITS-1:0] r;
    r      = v;
    r[0]   = 1'b0;
    r[9:7] = ocd_def ? 3'b111 : 3'b000;
    return r;
  endfunction

  assign ddr2_odt = 1'b0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    aref_nxt  = aref_cnt;
    dll_nxt   = (dll_cnt == DW'(T_DLL_CYC)) ? dll_cnt : dll_cnt + 1'b1;
    cke_nxt   = init_cke;
    cmd_nxt   = CMD_NOP;
    ba_nxt    = init_ba;
    addr_nxt  = init_addr;
    end_nxt   = init_end;
    busy_nxt  = init_busy;
    capture   = 1'b0;
    if (state == S_DONE) begin
      if (reinit_req) begin
        state_nxt = S_PRE1;
        cnt_nxt   = '0;
        end_nxt   = 1'b0;
        busy_nxt  = 1'b1;
        capture   = 1'b1;
      end
    end else if (cnt != '0) begin
      cnt_nxt = cnt - 1'b1;
    end else begin
      case (state)
        S_WAIT_PWR: begin
          cke_nxt = 1'b1; capture = 1'b1; cnt_nxt = gap(T_CKE_CYC); state_nxt = S_WAIT_CKE;
        end
        // The CKE wait is the gap in front of the first precharge.
        S_WAIT_CKE, S_PRE1: begin
          cmd_nxt = CMD_PRE; ba_nxt = '0; addr_nxt = ADDR_A10;
          cnt_nxt = gap(T_RP_CYC); state_nxt = S_EMR2;
        end
        S_EMR2: begin
          cmd_nxt = CMD_LM; ba_nxt = BA_BITS'(2); addr_nxt = emr2_q;
          cnt_nxt = gap(T_MRD_CYC); state_nxt = S_EMR3;
        end
        S_EMR3: begin
          cmd_nxt = CMD_LM; ba_nxt = BA_BITS'(3); addr_nxt = emr3_q;
          cnt_nxt = gap(T_MRD_CYC); state_nxt = S_EMR1_DLL;
        end
        S_EMR1_DLL: begin
          cmd_nxt = CMD_LM; ba_nxt = BA_BITS'(1); addr_nxt = emr1_word(emr1_q, 1'b0);
          cnt_nxt = gap(T_MRD_CYC); state_nxt = S_MR_DLLRST;
        end
        S_MR_DLLRST: begin
          cmd_nxt = CMD_LM; ba_nxt = '0; addr_nxt = mr_word(mr_q, 1'b1);
          cnt_nxt = gap(T_MRD_CYC); dll_nxt = '0; state_nxt = S_PRE2;
        end
        S_PRE2: begin
          cmd_nxt = CMD_PRE; ba_nxt = '0; addr_nxt = ADDR_A10;
          cnt_nxt = gap(T_RP_CYC); aref_nxt = '0; state_nxt = S_AREF;
        end
        S_AREF: begin
          cmd_nxt = CMD_AREF; cnt_nxt = gap(T_RFC_CYC);
          if (aref_cnt == AW'(N_AREF - 1)) state_nxt = S_MR_FINAL;
          else aref_nxt = aref_cnt + 1'b1;
        end
        S_MR_FINAL: begin
          cmd_nxt = CMD_LM; ba_nxt = '0; addr_nxt = mr_word(mr_q, 1'b0);
          cnt_nxt = gap(T_MRD_CYC);
`ifdef DDR2_OCD_EN
          state_nxt = S_EMR1_OCD_DEF;
`else
          state_nxt = S_EMR1_FINAL;
`endif
        end
        S_EMR1_OCD_DEF: begin
          cmd_nxt = CMD_LM; ba_nxt = BA_BITS'(1); addr_nxt = emr1_word(emr1_q, 1'b1);
          cnt_nxt = gap(T_MRD_CYC); state_nxt = S_EMR1_OCD_EXIT;
        end
        S_EMR1_OCD_EXIT: begin
          cmd_nxt = CMD_LM; ba_nxt = BA_BITS'(1); addr_nxt = emr1_word(emr1_q, 1'b0);
          cnt_nxt = gap(T_MRD_CYC); state_nxt = S_EMR1_FINAL;
        end
        S_EMR1_FINAL: begin
          cmd_nxt = CMD_LM; ba_nxt = BA_BITS'(1); addr_nxt = emr1_word(emr1_q, 1'b0);
          cnt_nxt = gap(T_MRD_CYC); state_nxt = S_WAIT_DLL;
        end
        S_WAIT_DLL: begin
          if (dll_cnt == DW'(T_DLL_CYC)) begin
            state_nxt = S_DONE; end_nxt = 1'b1; busy_nxt = 1'b0;
          end
        end
        default: state_nxt = S_WAIT_PWR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_WAIT_PWR;
      cnt       <= gap(T_PWR_CYC);
      dll_cnt   <= '0;
      aref_cnt  <= '0;
      init_cke  <= 1'b0;
      init_cmd  <= CMD_NOP;
      init_ba   <= '0;
      init_addr <= '0;
      init_end  <= 1'b0;
      init_busy <= 1'b1;
      mr_q      <= '0;
      emr1_q    <= '0;
      emr2_q    <= '0;
      emr3_q    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dll_cnt   <= dll_nxt;
      aref_cnt  <= aref_nxt;
      init_cke  <= cke_nxt;
      init_cmd  <= cmd_nxt;
      init_ba   <= ba_nxt;
      init_addr <= addr_nxt;
      init_end  <= end_nxt;
      init_busy <= busy_nxt;
      if (capture) begin
        mr_q   <= mr_val;
        emr1_q <= emr1_val;
        emr2_q <= emr2_val;
        emr3_q <= emr3_val;
      end
    end
  end

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Scoreboard bench for ddr2_init_seq: expected command stream queued at stimulus time, checked as commands appear.
module tb_ddr2_init_seq;
  localparam int T_PWR = 10, T_CKE = 4, T_RP = 3, T_MRD = 2, T_RFC = 5, N_AREF = 2, T_DLL = 40;
  localparam logic [3:0] CMD_NOP = 4'b0111, CMD_PRE = 4'b0010, CMD_AREF = 4'b0001, CMD_LM = 4'b0000;

  logic        clk = 1'b0, rst_n = 1'b0, reinit_req = 1'b0;
  logic [12:0] mr_val = 13'h0632, emr1_val = 13'h0044, emr2_val = 13'h0000, emr3_val = 13'h0000;
  logic        init_cke, ddr2_odt, init_busy, init_end;
  logic [3:0]  init_cmd;
  logic [2:0]  init_ba;
  logic [12:0] init_addr;
  logic        cke2, odt2, busy2, end2;
  logic [3:0]  cmd2;
  logic [2:0]  ba2;
  logic [12:0] addr2;

  ddr2_init_seq #(.BA_BITS(3), .ADDR_BITS(13), .T_PWR_CYC(T_PWR), .T_CKE_CYC(T_CKE), .T_RP_CYC(T_RP),
    .T_MRD_CYC(T_MRD), .T_RFC_CYC(T_RFC), .N_AREF(N_AREF), .T_DLL_CYC(T_DLL)) dut (
    .clk(clk), .rst_n(rst_n), .mr_val(mr_val), .emr1_val(emr1_val), .emr2_val(emr2_val),
    .emr3_val(emr3_val), .reinit_req(reinit_req), .init_cke(init_cke), .init_cmd(init_cmd),
    .init_ba(init_ba), .init_addr(init_addr), .ddr2_odt(ddr2_odt), .init_busy(init_busy),
    .init_end(init_end));

  // Same timing but a one-cycle DLL wait, so completion is limited by the last LM gap.
  ddr2_init_seq #(.BA_BITS(3), .ADDR_BITS(13), .T_PWR_CYC(T_PWR), .T_CKE_CYC(T_CKE), .T_RP_CYC(T_RP),
    .T_MRD_CYC(T_MRD), .T_RFC_CYC(T_RFC), .N_AREF(N_AREF), .T_DLL_CYC(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .mr_val(mr_val), .emr1_val(emr1_val), .emr2_val(emr2_val),
    .emr3_val(emr3_val), .reinit_req(reinit_req), .init_cke(cke2), .init_cmd(cmd2),
    .init_ba(ba2), .init_addr(addr2), .ddr2_odt(odt2), .init_busy(busy2), .init_end(end2));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [12:0] addr;
    int          gap;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0, last_t = 0, t_dll = 0, t_last2 = 0;
  int   errors = 0, checks = 0;
  logic end_d = 1'b0, end2_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [2:0] b, input logic [12:0] a, input int g);
    exp_t e;
    e.cmd = c; e.ba = b; e.addr = a; e.gap = g;
    q.push_back(e);
  endtask

  task automatic push_seq(input int first_gap);
    logic [12:0] e1, mdll, mfin;
    e1 = emr1_val; e1[0] = 1'b0; e1[9:7] = 3'b000;
    mdll = mr_val; mdll[8] = 1'b1;
    mfin = mr_val; mfin[8] = 1'b0;
    push(CMD_PRE, 3'd0, 13'h0400, first_gap);
    push(CMD_LM, 3'd2, emr2_val, T_RP);
    push(CMD_LM, 3'd3, emr3_val, T_MRD);
    push(CMD_LM, 3'd1, e1, T_MRD);
    push(CMD_LM, 3'd0, mdll, T_MRD);
    push(CMD_PRE, 3'd0, 13'h0400, T_MRD);
    push(CMD_AREF, 3'd0, 13'h0000, T_RP);
    for (int i = 1; i < N_AREF; i++) push(CMD_AREF, 3'd0, 13'h0000, T_RFC);
    push(CMD_LM, 3'd0, mfin, T_RFC);
`ifdef DDR2_OCD_EN
    push(CMD_LM, 3'd1, e1 | 13'h0380, T_MRD);
    push(CMD_LM, 3'd1, e1, T_MRD);
`endif
    push(CMD_LM, 3'd1, e1, T_MRD);
  endtask

  always @(negedge clk) begin
    if (rst_n && init_cmd !== CMD_NOP) begin
      if (q.size() == 0) begin
        check_val("extra_cmd", {init_cmd, init_ba, init_addr}, {CMD_NOP, 16'h0});
      end else begin
        mon_e = q.pop_front();
        check_val("cmd", init_cmd, mon_e.cmd);
        if (mon_e.cmd != CMD_AREF) begin
          check_val("ba", init_ba, mon_e.ba);
          check_val("addr", init_addr, mon_e.addr);
        end
        check_val("gap", cyc - last_t, mon_e.gap);
      end
      last_t = cyc;
      if (init_cmd == CMD_LM && init_ba == 3'd0 && init_addr[8]) t_dll = cyc;
    end
    if (rst_n && init_end && !end_d) begin
      check_val("dll_min", ((cyc - t_dll) >= T_DLL), 1);
      check_val("dll_late", ((cyc - t_dll) <= T_DLL + 1), 1);
      check_val("busy_at_end", init_busy, 0);
      check_val("q_empty_at_end", q.size(), 0);
    end
    end_d = init_end;
    if (rst_n && cmd2 !== CMD_NOP) t_last2 = cyc;
    if (rst_n && end2 && !end2_d) begin
      check_val("end2_gap", cyc - t_last2, T_MRD);
      check_val("busy2_at_end", busy2, 0);
    end
    end2_d = end2;
  end

  task automatic start_full();
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_t = cyc;
    push_seq(T_PWR + T_CKE);
    repeat (T_PWR - 1) @(posedge clk);
    #1 check_val("cke_early", init_cke, 0);
    @(posedge clk);
    #1 check_val("cke_rise", init_cke, 1);
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!init_end && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check_val(tag, init_end, 1);
  endtask

  task automatic wait_cmd(input string tag, input logic [3:0] c, input logic [2:0] b);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(init_cmd == c && init_ba == b) && n < 400);
    check_val(tag, {init_cmd, init_ba}, {c, b});
  endtask

  task automatic pulse_reinit(input logic [12:0] new_mr, input logic expect_seq);
    @(posedge clk); #1;
    mr_val = new_mr;
    reinit_req = 1'b1;
    if (expect_seq) begin
      last_t = cyc;
      push_seq(2);
    end
    @(posedge clk); #1;
    reinit_req = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cke", init_cke, 0);
    check_val("rst_cmd", init_cmd, CMD_NOP);
    check_val("rst_ba", init_ba, 0);
    check_val("rst_addr", init_addr, 0);
    check_val("rst_end", init_end, 0);
    check_val("rst_busy", init_busy, 1);
    check_val("rst_odt", ddr2_odt, 0);

    start_full();
    wait_end("end_timeout_1");

    pulse_reinit(13'h0A52, 1'b1);
    check_val("reinit_end", init_end, 0);
    check_val("reinit_busy", init_busy, 1);
    check_val("reinit_cke", init_cke, 1);

    wait_cmd("wait_aref", CMD_AREF, 3'd0);
    pulse_reinit(13'h0A52, 1'b0);
    wait_end("end_timeout_2");
    repeat (20) @(posedge clk);
    #1;
    check_val("no_queued_reinit", q.size(), 0);
    check_val("still_done", init_end, 1);

    pulse_reinit(13'h0632, 1'b1);
    wait_cmd("wait_emr3", CMD_LM, 3'd3);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_cke", init_cke, 0);
    check_val("arst_cmd", init_cmd, CMD_NOP);
    check_val("arst_end", init_end, 0);
    check_val("arst_busy", init_busy, 1);
    q.delete();
    repeat (3) @(posedge clk);
    start_full();
    wait_end("end_timeout_3");
    repeat (5) @(posedge clk);
    #1 check_val("final_q_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr2_init_seq.md
Name: ddr2_init_seq

Overview:
Parametrised DDR2 power-up initialisation sequencer. It replaces the fixed-timing, counter-decoded init block with an explicit FSM. Timing, refresh count and mode-register values are set by parameters and input ports, and a re-init request is supported. It sits between the PHY command mux and the controller core; the core holds off traffic until init_end is 1.

Parameters:
BA_BITS, 3, bank address width
ADDR_BITS, 13, row/mode address width (≥11)
T_PWR_CYC, 60000, CKE-low power-up wait in clocks (300 µs at 200 MHz)
T_CKE_CYC, 100, NOP wait after CKE rises before first PRE (≥400 ns)
T_RP_CYC, 4, PRE-to-next-command spacing in clocks
T_MRD_CYC, 2, LM-to-next-command spacing in clocks
T_RFC_CYC, 26, AREF-to-next-command spacing in clocks
N_AREF, 2, number of AREF commands (≥2)
T_DLL_CYC, 200, minimum clocks from DLL-reset LM to init_end

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mr_val  in  ADDR_BITS  MR value (A8 ignored; forced by FSM)
emr1_val  in  ADDR_BITS  EMR1 value (A0 and A9:A7 ignored; forced by FSM)
emr2_val  in  ADDR_BITS  EMR2 value
emr3_val  in  ADDR_BITS  EMR3 value
reinit_req  in  1  one-cycle request to rerun the sequence
init_cke  out  1  CKE to DRAM
init_cmd  out  4  {cs_n,ras_n,cas_n,we_n}: NOP 0111, PRE 0010, AREF 0001, LM 0000
init_ba  out  BA_BITS  bank address
init_addr  out  ADDR_BITS  address
ddr2_odt  out  1  ODT, tied 0
init_busy  out  1  sequence in progress
init_end  out  1  sequence complete; core may issue commands

Behaviour:
- Reset values: init_cke=0, init_cmd=NOP, init_ba=0, init_addr=0, init_end=0, init_busy=1, ddr2_odt=0. All outputs except ddr2_odt are registered.
- One gap counter is loaded when each command issues. The next command appears exactly T_x cycles after the previous one, where T_x is the spacing for the previous command type. Each command lasts one cycle; init_cmd is NOP at all other times.
- DLL counter: cleared when MR_DLLRST issues, then saturates at T_DLL_CYC.
- mr/emr inputs are captured into internal registers on leaving WAIT_PWR and on reinit acceptance. Later input changes have no effect on the running sequence.
- FSM states:
  - WAIT_PWR: NOP, CKE=0, for T_PWR_CYC cycles. init_cke goes to 1 on the edge that leaves this state.
  - WAIT_CKE: NOP for T_CKE_CYC cycles.
  - PRE1: PRE, A10=1, other address bits 0.
  - EMR2: LM, ba=2, addr=emr2.
  - EMR3: LM, ba=3, addr=emr3.
  - EMR1_DLL: LM, ba=1, emr1 with A0=0 and A9:A7=000.
  - MR_DLLRST: LM, ba=0, mr with A8=1.
  - PRE2: PRE, A10=1.
  - AREF: repeated N_AREF times, each followed by T_RFC_CYC spacing.
  - MR_FINAL: LM, ba=0, mr with A8=0.
  - EMR1_FINAL: LM, ba=1, emr1 with A0=0 and A9:A7=000.
  - WAIT_DLL: NOP until both the gap counter and the DLL counter have expired.
  - DONE: init_end=1, init_busy=0.
- init_ba and init_addr hold their last values during NOPs.
- Re-init: reinit_req is honoured only in DONE.
  - Next cycle: init_end=0, init_busy=1, state PRE1. WAIT_PWR and WAIT_CKE are skipped; CKE stays 1.
  - PRE1 issues on the following cycle.
  - reinit_req asserted while busy is ignored and not queued.
- Reset asserted mid-sequence: all outputs return to reset values immediately (CKE drops). The sequence restarts from WAIT_PWR.
- Spacing parameters are ≥1. A value of 1 gives back-to-back commands.

Optional Feature:
DDR2_OCD_EN
- Defined: after MR_FINAL, insert two states before EMR1_FINAL:
  - EMR1_OCD_DEF: LM, ba=1, emr1 with A9:A7=111.
  - EMR1_OCD_EXIT: LM, ba=1, emr1 with A9:A7=000.
  - Each is followed by T_MRD_CYC spacing.
  - EMR1_FINAL then issues as normal (the second OCD write and EMR1_FINAL are both A9:A7=000).
- Undefined: MR_FINAL is followed directly by EMR1_FINAL.

Test Plan:
1. Params T_PWR_CYC=10, T_CKE_CYC=4, T_RP_CYC=3, T_MRD_CYC=2, T_RFC_CYC=5, N_AREF=2, T_DLL_CYC=40; mr_val=0x0632, emr1_val=0x0044, emr2=0, emr3=0; release reset → CKE rises 10 cycles after reset release; first PRE 4 cycles later with addr=0x0400. Then, in order:
   - LM ba2 0x0000, LM ba3 0x0000, LM ba1 0x0044, LM ba0 0x0732, each spaced 3/2/2/2 as appropriate;
   - PRE 0x0400;
   - AREF ×2, spaced 5;
   - LM ba0 0x0632, LM ba1 0x0044;
   - init_end stays 0 until ≥40 cycles after the 0x0732 LM.
2. Same params with T_DLL_CYC=1 → init_end rises T_MRD_CYC cycles after EMR1_FINAL (gap-limited); init_busy falls on the same edge.
3. In DONE, pulse reinit_req; change mr_val to 0x0A52 in the same cycle → init_end=0 next cycle; CKE stays 1; PRE follows with no 10/4-cycle waits; DLL-reset LM = 0x0B52.
4. Pulse reinit_req during AREF → ignored; sequence completes unchanged with exactly 2 AREFs.
5. Assert rst_n=0 during the EMR3 gap → CKE=0, cmd=NOP, init_end=0 asynchronously; after release the full sequence reruns from WAIT_PWR.
6. Build with DDR2_OCD_EN, emr1_val=0x0044 → after MR_FINAL: LM ba1 0x03C4, LM ba1 0x0044, then EMR1_FINAL 0x0044; without the macro no 0x03C4 command ever appears.
